multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multicycle successor of the single-cycle RISC-V controller: a Moore FSM sequencing each RV32I instruction over 3–5 cycles on a shared ALU and unified instruction/data memory. Adds a memory-ready handshake, all six conditional branches, JALR, LUI/AUIPC, illegal-instruction trapping and a selectable ALU-control width. It sits between the instruction register and the multicycle datapath (PC, OldPC, A/B, ALUOut, Data registers).

## Interface
- ALUCTRL_W, 3, ALUControl width; 3 = add/sub/and/or/xor/slt only, 4 = adds sltu, sll, srl, sra
- BRANCH_EXT, 1, 1 = beq/bne/blt/bge/bltu/bgeu; 0 = beq/bne only, others illegal
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- op  in  7  instruction opcode from IR
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero, LT, LTU  in  1 each  ALU flags for rs1−rs2 (equal, signed less, unsigned less)
- MemReady  in  1  memory completes current access this cycle
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  write enables
- AdrSrc  out  1  0 = PC, 1 = ALUOut onto memory address
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A (rs1), 11 zero
- ALUSrcB  out  2  00 B (rs2), 01 ImmExt, 10 constant 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded from op each cycle
- ALUControl  out  ALUCTRL_W  add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9
- Illegal  out  1  high while in TRAP
- State  out  4  current state encoding (debug)

## Operation
- States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRPC 12, UPPER 13, TRAP 14; 15 unreachable, recovers to FETCH.
- Unlisted outputs 0; ALUOp: 00 add, 01 sub, 10 funct-decoded.
- FETCH: AdrSrc 0, A=PC, B=4, add, ResultSrc 10; IRWrite = PCWrite = MemReady; stays until MemReady, then DECODE.
- DECODE: A=OldPC, B=Imm, add (branch/jal target into ALUOut). Next: lw/sw→MEMADR, R→EXECR, I-ALU→EXECI, branch→BRANCH, jal→JAL, jalr→JALR, lui/auipc→UPPER; else TRAP.
- MEMADR: A=rs1, B=Imm, add; lw→MEMREAD, sw→MEMWRITE.
- MEMREAD: AdrSrc 1; waits for MemReady→MEMWB. MEMWB: ResultSrc 01, RegWrite→FETCH.
- MEMWRITE: AdrSrc 1, MemWrite held 1 until MemReady→FETCH.
- EXECR: A=rs1, B=rs2, ALUOp 10. EXECI: A=rs1, B=Imm, ALUOp 10. Both→ALUWB.
- ALUWB: ResultSrc 00, RegWrite→FETCH.
- BRANCH: A=rs1, B=rs2, sub, ResultSrc 00; PCWrite = taken→FETCH. taken: 000 Zero, 001 !Zero, 100 LT, 101 !LT, 110 LTU, 111 !LTU.
- JAL: A=OldPC, B=4, add, ResultSrc 00, PCWrite→ALUWB.
- JALR: A=OldPC, B=4, ResultSrc 10, RegWrite→JALRPC. JALRPC: A=rs1 (A latched in DECODE, so rd==rs1 safe), B=Imm, add, ResultSrc 10, PCWrite→FETCH.
- UPPER: A = zero (lui) or OldPC (auipc), B=Imm, add→ALUWB.
- ALU decode (ALUOp 10): funct3 000 sub iff funct7b5&op[5] else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 sra if funct7b5 else srl; 110 or; 111 and.
- Illegal (detected in DECODE/EXEC entry, →TRAP): unknown op; branch funct3 010/011; BRANCH_EXT=0 and funct3[2]=1; ALUCTRL_W=3 with funct3 001/011/101 in R/I ops.
- TRAP: all enables 0, Illegal 1; held until reset.

## Timing
- reset low: State=FETCH immediately; all write enables forced 0 while low; Illegal 0.
- First FETCH edge after reset release.
- Cycles with MemReady always 1: lw 5; sw, R, I, jal, jalr, lui, auipc 4; branch 3. Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
- Reset mid-instruction: abandon, FETCH; no partial register/memory write after reset asserts.

## Test plan
- Reset low mid-MEMWRITE → State 0, MemWrite 0 same cycle; release → FETCH.
- add (op 0110011, f3 000, f7b5 0), MemReady=1 → states 0,1,6,8; ALUControl 0 in EXECR; RegWrite only in ALUWB.
- lw with MemReady low 2 cycles in FETCH and 1 in MEMREAD → 8 cycles total; IRWrite pulses once.
- bge with LT=0 → PCWrite 1 in BRANCH; LT=1 → 0; bltu under BRANCH_EXT=0 → TRAP, Illegal 1.
- jalr → JALR RegWrite 1 ResultSrc 10; JALRPC PCWrite 1 ALUSrcA 10 ALUSrcB 01.
- sra (f3 101, f7b5 1) → ALUControl 9 at ALUCTRL_W=4; TRAP at ALUCTRL_W=3.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, ALU flags and memory handshake in,
// datapath control out, between the multicycle controller (slave) and its datapath (master).
interface multicycle_controller_if #(parameter int ALUCTRL_W = 3);
   logic [6:0]           op;
   logic [2:0]           funct3;
   logic                 funct7b5, Zero, LT, LTU, MemReady;
   logic                 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal;
   logic [1:0]           ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0]           ImmSrc;
   logic [ALUCTRL_W-1:0] ALUControl;
   logic [3:0]           State;
   modport slave (
      input  op, funct3, funct7b5, Zero, LT, LTU, MemReady,
      output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal,
             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State
   );
   modport master (
      output op, funct3, funct7b5, Zero, LT, LTU, MemReady,
      input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal,
             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State
   );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing RV32I instructions over a shared ALU and unified memory.
module multicycle_controller #(
   parameter int ALUCTRL_W  = 3,
   parameter bit BRANCH_EXT = 1'b1
) (
   input logic                   clk,
   input logic                   reset,
   multicycle_controller_if.slave bus
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
      MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
      JAL = 4'd10, JALR = 4'd11, JALRPC = 4'd12, UPPER = 4'd13, TRAP = 4'd14
   } state_t;
   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
   localparam bit NARROW = ALUCTRL_W < 4;
   state_t               state, nxt;
   logic                 is_lw, is_sw, is_r, is_i, is_br, is_jal, is_jalr, is_lui, is_auipc;
   logic                 bad, taken, fetch_go;
   logic [3:0]           alu_f;
   logic [1:0]           n_a, n_b, n_res, src_a, src_b, res;
   logic [ALUCTRL_W-1:0] n_alu, alu;
   logic                 n_adr, n_rw, n_mw, n_pcw, n_ill, adr, rw, mw, pcw, ill;
   assign is_lw    = bus.op == OP_LW;
   assign is_sw    = bus.op == OP_SW;
   assign is_r     = bus.op == OP_R;
   assign is_i     = bus.op == OP_I;
   assign is_br    = bus.op == OP_BR;
   assign is_jal   = bus.op == OP_JAL;
   assign is_jalr  = bus.op == OP_JALR;
   assign is_lui   = bus.op == OP_LUI;
   assign is_auipc = bus.op == OP_AUIPC;
   // narrow ALU has no sll/sltu/srl/sra, so those R/I encodings trap
   assign bad = ((is_r | is_i) && NARROW && (bus.funct3 inside {3'b001, 3'b011, 3'b101})) ||
                (is_br && (bus.funct3[2:1] == 2'b01 || (!BRANCH_EXT && bus.funct3[2])));
   assign taken = bus.funct3[0] ^ (bus.funct3[2] ? (bus.funct3[1] ? bus.LTU : bus.LT) : bus.Zero);
   always_comb
      case (bus.funct3)
         3'b000:  alu_f = (bus.funct7b5 & bus.op[5]) ? 4'd1 : 4'd0;
         3'b001:  alu_f = 4'd7;
         3'b010:  alu_f = 4'd5;
         3'b011:  alu_f = 4'd6;
         3'b100:  alu_f = 4'd4;
         3'b101:  alu_f = bus.funct7b5 ? 4'd9 : 4'd8;
         3'b110:  alu_f = 4'd3;
         default: alu_f = 4'd2;
      endcase
   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:    nxt = bus.MemReady ? DECODE : FETCH;
         DECODE:   nxt = bad ? TRAP : (is_lw | is_sw) ? MEMADR : is_r ? EXECR : is_i ? EXECI :
                         is_br ? BRANCH : is_jal ? JAL : is_jalr ? JALR :
                         (is_lui | is_auipc) ? UPPER : TRAP;
         MEMADR:   nxt = is_sw ? MEMWRITE : MEMREAD;
         MEMREAD:  nxt = bus.MemReady ? MEMWB : MEMREAD;
         MEMWRITE: nxt = bus.MemReady ? FETCH : MEMWRITE;
         EXECR, EXECI, JAL, UPPER: nxt = ALUWB;
         JALR:     nxt = JALRPC;
         TRAP:     nxt = TRAP;
         default:  nxt = FETCH;
      endcase
   end
   // outputs are decoded from the next state so they are registered alongside it
   always_comb begin
      n_a   = 2'b00;
      n_b   = 2'b00;
      n_res = 2'b00;
      n_alu = '0;
      n_adr = 1'b0;
      n_rw  = 1'b0;
      n_mw  = 1'b0;
      n_pcw = 1'b0;
      n_ill = 1'b0;
      case (nxt)
         FETCH:    begin n_b = 2'b10; n_res = 2'b10; end
         DECODE:   begin n_a = 2'b01; n_b = 2'b01; end
         MEMADR:   begin n_a = 2'b10; n_b = 2'b01; end
         MEMREAD:  n_adr = 1'b1;
         MEMWB:    begin n_res = 2'b01; n_rw = 1'b1; end
         MEMWRITE: begin n_adr = 1'b1; n_mw = 1'b1; end
         EXECR:    begin n_a = 2'b10; n_alu = ALUCTRL_W'(alu_f); end
         EXECI:    begin n_a = 2'b10; n_b = 2'b01; n_alu = ALUCTRL_W'(alu_f); end
         ALUWB:    n_rw = 1'b1;
         BRANCH:   begin n_a = 2'b10; n_alu = ALUCTRL_W'(1); end
         JAL:      begin n_a = 2'b01; n_b = 2'b10; n_pcw = 1'b1; end
         JALR:     begin n_a = 2'b01; n_b = 2'b10; n_res = 2'b10; n_rw = 1'b1; end
         JALRPC:   begin n_a = 2'b10; n_b = 2'b01; n_res = 2'b10; n_pcw = 1'b1; end
         UPPER:    begin n_a = is_lui ? 2'b11 : 2'b01; n_b = 2'b01; end
         TRAP:     n_ill = 1'b1;
         default:  ;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= FETCH;
         src_a <= 2'b00;
         src_b <= 2'b10;
         res   <= 2'b10;
         alu   <= '0;
         adr   <= 1'b0;
         rw    <= 1'b0;
         mw    <= 1'b0;
         pcw   <= 1'b0;
         ill   <= 1'b0;
      end else begin
         state <= nxt;
         src_a <= n_a;
         src_b <= n_b;
         res   <= n_res;
         alu   <= n_alu;
         adr   <= n_adr;
         rw    <= n_rw;
         mw    <= n_mw;
         pcw   <= n_pcw;
         ill   <= n_ill;
      end
   // fetch and branch enables follow this cycle's MemReady / flags, gated by reset
   assign fetch_go       = reset && state == FETCH && bus.MemReady;
   assign bus.IRWrite    = fetch_go;
   assign bus.PCWrite    = pcw | fetch_go | (reset && state == BRANCH && taken);
   assign bus.RegWrite   = rw;
   assign bus.MemWrite   = mw;
   assign bus.AdrSrc     = adr;
   assign bus.Illegal    = ill;
   assign bus.ResultSrc  = res;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ALUControl = alu;
   assign bus.State      = state;
   assign bus.ImmSrc     = is_sw ? 3'b001 : is_br ? 3'b010 : is_jal ? 3'b011 :
                           (is_lui | is_auipc) ? 3'b100 : 3'b000;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle controller, wide ALU with all
// branches (dut4) and narrow ALU with beq/bne only (dut3), driven by the same instruction stream.
module tb_multicycle_controller;
   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
   logic       clk = 1'b0, reset = 1'b0, f7 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mr = 1'b1;
   logic [6:0] op = OP_R;
   logic [2:0] f3 = 3'b000;
   int         n_assert = 0, n_fail = 0, cyc = 0, irp = 0, c0 = 0, i0 = 0;
   always #5 clk = ~clk;
   multicycle_controller_if #(.ALUCTRL_W(4)) b4 ();
   multicycle_controller_if #(.ALUCTRL_W(3)) b3 ();
   assign b4.op = op;
   assign b4.funct3 = f3;
   assign b4.funct7b5 = f7;
   assign b4.Zero = zero;
   assign b4.LT = lt;
   assign b4.LTU = ltu;
   assign b4.MemReady = mr;
   assign b3.op = op;
   assign b3.funct3 = f3;
   assign b3.funct7b5 = f7;
   assign b3.Zero = zero;
   assign b3.LT = lt;
   assign b3.LTU = ltu;
   assign b3.MemReady = mr;
   multicycle_controller #(.ALUCTRL_W(4), .BRANCH_EXT(1'b1)) dut4 (.clk(clk), .reset(reset), .bus(b4));
   multicycle_controller #(.ALUCTRL_W(3), .BRANCH_EXT(1'b0)) dut3 (.clk(clk), .reset(reset), .bus(b3));
   always @(negedge clk) if (b4.IRWrite) irp++;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic next();
      @(posedge clk);
      #2;
      cyc++;
   endtask
   task automatic setir(input logic [6:0] o, input logic [2:0] f, input logic b);
      op = o;
      f3 = f;
      f7 = b;
   endtask
   initial begin
      next();
      next();
      #1;
      chk("rst.state", b4.State, 0);
      chk("rst.irwrite", b4.IRWrite, 0);
      chk("rst.pcwrite", b4.PCWrite, 0);
      chk("rst.illegal", b4.Illegal, 0);
      chk("rst.alusrcb", b4.ALUSrcB, 2);
      chk("rst.state3", b3.State, 0);
      reset = 1'b1;
      #1;
      chk("add.f.irwrite", b4.IRWrite, 1);
      chk("add.f.pcwrite", b4.PCWrite, 1);
      chk("add.f.resultsrc", b4.ResultSrc, 2);
      chk("add.f.regwrite", b4.RegWrite, 0);
      c0 = cyc;
      next();
      chk("add.d.state", b4.State, 1);
      chk("add.d.alusrca", b4.ALUSrcA, 1);
      chk("add.d.alusrcb", b4.ALUSrcB, 1);
      chk("add.d.irwrite", b4.IRWrite, 0);
      next();
      chk("add.e.state", b4.State, 6);
      chk("add.e.aluctl", b4.ALUControl, 0);
      chk("add.e.alusrca", b4.ALUSrcA, 2);
      chk("add.e.alusrcb", b4.ALUSrcB, 0);
      chk("add.e.regwrite", b4.RegWrite, 0);
      chk("add.e.state3", b3.State, 6);
      next();
      chk("add.wb.state", b4.State, 8);
      chk("add.wb.regwrite", b4.RegWrite, 1);
      chk("add.wb.resultsrc", b4.ResultSrc, 0);
      next();
      chk("add.done.state", b4.State, 0);
      chk("add.cycles", cyc - c0, 4);
      setir(OP_R, 3'b000, 1'b1);
      next();
      next();
      chk("sub.aluctl", b4.ALUControl, 1);
      chk("sub.aluctl3", b3.ALUControl, 1);
      next();
      next();
      setir(OP_I, 3'b000, 1'b1);
      next();
      next();
      chk("addi.state", b4.State, 7);
      chk("addi.aluctl", b4.ALUControl, 0);
      chk("addi.alusrcb", b4.ALUSrcB, 1);
      next();
      next();
      setir(OP_LW, 3'b010, 1'b0);
      mr = 1'b0;
      #1;
      i0 = irp;
      c0 = cyc;
      chk("lw.f0.irwrite", b4.IRWrite, 0);
      chk("lw.f0.pcwrite", b4.PCWrite, 0);
      next();
      chk("lw.f1.state", b4.State, 0);
      next();
      mr = 1'b1;
      #1;
      chk("lw.f2.irwrite", b4.IRWrite, 1);
      next();
      chk("lw.d.state", b4.State, 1);
      next();
      chk("lw.adr.state", b4.State, 2);
      chk("lw.adr.alusrca", b4.ALUSrcA, 2);
      next();
      mr = 1'b0;
      #1;
      chk("lw.rd.state", b4.State, 3);
      chk("lw.rd.adrsrc", b4.AdrSrc, 1);
      next();
      chk("lw.rd.wait", b4.State, 3);
      mr = 1'b1;
      next();
      chk("lw.wb.state", b4.State, 4);
      chk("lw.wb.resultsrc", b4.ResultSrc, 1);
      chk("lw.wb.regwrite", b4.RegWrite, 1);
      next();
      chk("lw.done.state", b4.State, 0);
      chk("lw.cycles", cyc - c0, 8);
      chk("lw.irpulses", irp - i0, 1);
      setir(OP_JALR, 3'b000, 1'b0);
      next();
      next();
      chk("jalr.state", b4.State, 11);
      chk("jalr.regwrite", b4.RegWrite, 1);
      chk("jalr.resultsrc", b4.ResultSrc, 2);
      chk("jalr.pcwrite", b4.PCWrite, 0);
      next();
      chk("jalrpc.state", b4.State, 12);
      chk("jalrpc.pcwrite", b4.PCWrite, 1);
      chk("jalrpc.alusrca", b4.ALUSrcA, 2);
      chk("jalrpc.alusrcb", b4.ALUSrcB, 1);
      chk("jalrpc.regwrite", b4.RegWrite, 0);
      next();
      chk("jalr.done.state", b4.State, 0);
      setir(OP_JAL, 3'b000, 1'b0);
      next();
      chk("jal.immsrc", b4.ImmSrc, 3);
      next();
      chk("jal.state", b4.State, 10);
      chk("jal.pcwrite", b4.PCWrite, 1);
      chk("jal.resultsrc", b4.ResultSrc, 0);
      next();
      chk("jal.wb.state", b4.State, 8);
      next();
      setir(OP_LUI, 3'b000, 1'b0);
      next();
      chk("lui.immsrc", b4.ImmSrc, 4);
      next();
      chk("lui.state", b4.State, 13);
      chk("lui.alusrca", b4.ALUSrcA, 3);
      next();
      next();
      setir(OP_AUIPC, 3'b000, 1'b0);
      next();
      next();
      chk("auipc.alusrca", b4.ALUSrcA, 1);
      next();
      next();
      setir(OP_R, 3'b101, 1'b1);
      next();
      next();
      chk("sra.state", b4.State, 6);
      chk("sra.aluctl", b4.ALUControl, 9);
      chk("sra.trap3", b3.State, 14);
      chk("sra.illegal3", b3.Illegal, 1);
      next();
      chk("sra.wb.state", b4.State, 8);
      chk("sra.regwrite3", b3.RegWrite, 0);
      next();
      chk("sra.done.state", b4.State, 0);
      chk("sra.held3", b3.State, 14);
      reset = 1'b0;
      #1;
      chk("rst2.state3", b3.State, 0);
      chk("rst2.illegal3", b3.Illegal, 0);
      next();
      reset = 1'b1;
      setir(OP_BR, 3'b000, 1'b0);
      zero = 1'b1;
      next();
      chk("beq.immsrc", b4.ImmSrc, 2);
      next();
      chk("beq.state", b4.State, 9);
      chk("beq.taken", b4.PCWrite, 1);
      chk("beq.taken3", b3.PCWrite, 1);
      zero = 1'b0;
      #1;
      chk("beq.nottaken", b4.PCWrite, 0);
      next();
      chk("beq.done.state", b4.State, 0);
      setir(OP_BR, 3'b110, 1'b0);
      ltu = 1'b1;
      next();
      next();
      chk("bltu.taken", b4.PCWrite, 1);
      chk("bltu.trap3", b3.State, 14);
      chk("bltu.illegal3", b3.Illegal, 1);
      chk("bltu.pcwrite3", b3.PCWrite, 0);
      next();
      setir(OP_BR, 3'b101, 1'b0);
      ltu = 1'b0;
      lt = 1'b0;
      next();
      next();
      chk("bge.state", b4.State, 9);
      chk("bge.aluctl", b4.ALUControl, 1);
      chk("bge.taken", b4.PCWrite, 1);
      lt = 1'b1;
      #1;
      chk("bge.nottaken", b4.PCWrite, 0);
      next();
      chk("bge.done.state", b4.State, 0);
      setir(OP_BR, 3'b010, 1'b0);
      next();
      next();
      chk("br010.trap", b4.State, 14);
      chk("br010.illegal", b4.Illegal, 1);
      chk("br010.pcwrite", b4.PCWrite, 0);
      reset = 1'b0;
      next();
      reset = 1'b1;
      setir(OP_SW, 3'b010, 1'b0);
      next();
      chk("sw.immsrc", b4.ImmSrc, 1);
      next();
      chk("sw.adr.state", b4.State, 2);
      mr = 1'b0;
      next();
      chk("sw.wr.state", b4.State, 5);
      chk("sw.wr.memwrite", b4.MemWrite, 1);
      chk("sw.wr.adrsrc", b4.AdrSrc, 1);
      mr = 1'b1;
      #1;
      next();
      chk("sw.done.state", b4.State, 0);
      chk("sw.done.memwrite", b4.MemWrite, 0);
      mr = 1'b1;
      next();
      next();
      mr = 1'b0;
      next();
      next();
      chk("sw2.wr.held", b4.MemWrite, 1);
      reset = 1'b0;
      #1;
      chk("sw2.rst.state", b4.State, 0);
      chk("sw2.rst.memwrite", b4.MemWrite, 0);
      chk("sw2.rst.memwrite3", b3.MemWrite, 0);
      next();
      reset = 1'b1;
      #1;
      chk("sw2.rel.state", b4.State, 0);
      chk("sw2.rel.irwrite", b4.IRWrite, 0);
      mr = 1'b1;
      setir(7'b0000000, 3'b000, 1'b0);
      next();
      next();
      chk("bad.state", b4.State, 14);
      chk("bad.illegal", b4.Illegal, 1);
      chk("bad.irwrite", b4.IRWrite, 0);
      chk("bad.pcwrite", b4.PCWrite, 0);
      next();
      chk("bad.held", b4.State, 14);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
